// File: rtl/logic_16b_seq.sv
// logic_16b_seq: nibble-serial AND/OR/XOR/NOT using one shared 4-bit slice
module logic_16b_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [4*NIBBLES-1:0]   x,
  input  logic [4*NIBBLES-1:0]   y,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   o
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] xr, yr;
  logic [1:0] opr;
  logic [CW-1:0] cnt;
  logic [3:0] xn, yn, nib;
  logic last;
  always_comb begin
    xn = xr[4*cnt +: 4];
    yn = yr[4*cnt +: 4];
    nib = opr == 2'b00 ? xn & yn : opr == 2'b01 ? xn | yn : opr == 2'b10 ? xn ^ yn : ~xn;
    last = cnt == CW'(NIBBLES - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xr <= '0;
      yr <= '0;
      opr <= '0;
      cnt <= '0;
      o <= '0;
    end else if (state == IDLE && start) begin
      xr <= x;
      yr <= y;
      opr <= op;
      cnt <= '0;
      o <= '0;
    end else if (state == RUN) begin
      o[4*cnt +: 4] <= nib;
      cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_logic_16b_seq.sv
// tb_logic_16b_seq: scoreboard bench for logic_16b_seq
module tb_logic_16b_seq;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [1:0] op = 0;
  logic [15:0] x = 0, y = 0, o;
  int n_vec = 0, n_err = 0, done_cnt = 0, cyc = 0;
  int done_cyc[$];
  logic [15:0] exp_q[$];
  logic_16b_seq dut (.clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
                     .busy(busy), .done(done), .o(o));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (done) begin
    done_cnt++;
    done_cyc.push_back(cyc);
    if (exp_q.size() == 0) check("spurious_done", 1, 0);
    else check("result", o, exp_q.pop_front());
  end
  task automatic issue(logic [1:0] p, logic [15:0] a, logic [15:0] b);
    @(posedge clk); #1;
    start = 1; op = p; x = a; y = b;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_dones(int target);
    int k = 0;
    while (done_cnt < target && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_timeout", done_cnt >= target, 1);
  endtask
  initial begin
    int k, b, d0;
    logic [15:0] fill[4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
    #12;
    check("rst_o", o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst = 0;
    exp_q.push_back(16'hF000);
    issue(2'b00, 16'hF0F0, 16'hFF00);
    k = 0; b = 0;
    do begin
      @(negedge clk);
      k++;
      b += int'(busy);
    end while (!done && k < 20);
    check("and_latency", k, 5);
    check("and_busy_cycles", b, 5);
    @(negedge clk);
    check("and_idle_busy", busy, 0);
    check("and_done_once", done, 0);
    check("and_hold", o, 16'hF000);
    exp_q.push_back(16'h5335); issue(2'b01, 16'h1234, 16'h4321); wait_dones(2);
    exp_q.push_back(16'h5555); issue(2'b10, 16'hAAAA, 16'hFFFF); wait_dones(3);
    exp_q.push_back(16'hFF00); issue(2'b11, 16'h00FF, 16'h1234); wait_dones(4);
    exp_q.push_back(16'hFFFF);
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    check("fill_clear", o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill", o, fill[i]);
    end
    wait_dones(5);
    exp_q.push_back(16'h5335);
    issue(2'b01, 16'h1234, 16'h4321);
    start = 1; op = 2'b10; x = 0; y = 16'hFFFF;
    @(posedge clk); #1;
    start = 0;
    wait_dones(6);
    repeat (8) @(posedge clk);
    #1 check("reject_one_done", done_cnt, 6);
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    @(posedge clk); @(posedge clk); #2;
    rst = 1; #1;
    check("abort_o", o, 0);
    check("abort_busy", busy, 0);
    #1 rst = 0;
    repeat (8) @(posedge clk);
    #1 check("abort_no_done", done_cnt, 6);
    exp_q.push_back(16'h0F0F); issue(2'b00, 16'h0F0F, 16'hFFFF); wait_dones(7);
    exp_q.push_back(16'h5555);
    exp_q.push_back(16'h5335);
    @(posedge clk); #1;
    start = 1; op = 2'b10; x = 16'hAAAA; y = 16'hFFFF;
    @(posedge clk); #1;
    op = 2'b01; x = 16'h1234; y = 16'h4321;
    wait_dones(8);
    @(posedge clk); @(posedge clk); #1;
    start = 0;
    check("b2b_recapture", busy, 1);
    wait_dones(9);
    d0 = done_cyc.size();
    if (d0 >= 2) check("b2b_spacing", done_cyc[d0-1] - done_cyc[d0-2], 6);
    else check("b2b_count", d0, 2);
    repeat (10) @(posedge clk);
    #1 check("b2b_no_third", done_cnt, 9);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/logic_16b_seq.md
LOGIC_16B_SEQ -- requirements
Module: logic_16b_seq

Interface
REQ-001 The parameter NIBBLES, default 4, SHALL set the number of 4-bit slices per operation; data width W = 4*NIBBLES.
REQ-002 The port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 The port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 The port start, input, 1 bit, SHALL request a new operation; sampled on the rising clk edge.
REQ-005 The port op, input, 2 bits, SHALL select the operation: 00 AND, 01 OR, 10 XOR, 11 NOT x (y ignored).
REQ-006 The port x, input, W bits, SHALL be operand A.
REQ-007 The port y, input, W bits, SHALL be operand B.
REQ-008 The port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-009 The port done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-010 The port o, output, W bits, SHALL be the registered result.

Function
REQ-011 The block SHALL contain exactly one 4-bit logic slice (AND/OR/XOR/NOT per op), reused once per nibble; no W-wide logic operator on the operands.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL capture x, y and op into internal registers, clear o to 0, clear the nibble counter to 0 and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL hold all state; o keeps the last result.
REQ-015 In RUN, each edge SHALL write slice(op, xr[4i+3:4i], yr[4i+3:4i]) into o[4i+3:4i] for counter value i, then increment the counter; processing is LSB nibble first.
REQ-016 In RUN, when the counter equals NIBBLES-1, that edge SHALL write the last nibble and enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge E0, nibble i SHALL be written at edge E0+1+i, and done SHALL be high in the cycle following edge E0+NIBBLES (5 edges for the default).
REQ-019 start in RUN or DONE SHALL be ignored; captured operands and op SHALL not change, and there is no queuing.
REQ-020 Changes on x, y and op after capture SHALL not affect the in-flight result.
REQ-021 o SHALL remain stable from DONE until the next accepted start.
REQ-022 With start held high continuously, a new operation SHALL be accepted at the first edge in IDLE after DONE, giving one operation per NIBBLES+2 cycles.
REQ-023 The nibble counter SHALL be clog2(NIBBLES) bits wide, minimum 1, and SHALL never be used to index beyond NIBBLES-1.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, o=0, done=0, busy=0, and clear the captured operand and op registers.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first edge after rst deasserts with start=1 SHALL begin a fresh operation.

Verification
REQ-026 AND: x=16'hF0F0, y=16'hFF00, op=00, one-cycle start -> busy high for 5 cycles, done pulses once in cycle 5, o=16'hF000.
REQ-027 OR/XOR/NOT: 16'h1234|16'h4321 -> 16'h5335; 16'hAAAA^16'hFFFF -> 16'h5555; op=11, x=16'h00FF -> 16'hFF00.
REQ-028 Progressive fill: x=16'hFFFF, y=16'hFFFF, AND -> o reads 000F, 00FF, 0FFF, FFFF on successive RUN edges.
REQ-029 Busy rejection: start again during RUN with x=16'h0000 and changed op -> ignored; the first result completes unchanged with exactly one done pulse.
REQ-030 Reset mid-op: rst pulsed after 2 nibbles, between clock edges -> o=0, busy=0 immediately, no done pulse; a following AND of 16'h0F0F and 16'hFFFF -> 16'h0F0F.
REQ-031 Back-to-back: start held high for two operations -> second capture at the edge after DONE, done pulses 6 cycles apart.
